// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookups are combinational on the fetch PC. EX resolution feedback updates the table and statistics.
module branch_target_predictor #(
    parameter int BIT_W   = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIT_W-1:0] if_pc_i,
    output logic             pred_hit_o,
    output logic             pred_taken_o,
    output logic [BIT_W-1:0] pred_target_o,
    input  logic             fb_valid_i,
    input  logic [BIT_W-1:0] fb_pc_i,
    input  logic             fb_taken_i,
    input  logic             fb_jump_i,
    input  logic [BIT_W-1:0] fb_target_i,
    input  logic             fb_correction_i,
    input  logic             flush_i,
    output logic [31:0]      stat_resolved_o,
    output logic [31:0]      stat_mispred_o
);

    localparam int TAG_W = BIT_W - IDX_W - 1;
    localparam logic [1:0] CTR_SN = 2'b00;
    localparam logic [1:0] CTR_WN = 2'b01;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jump_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [BIT_W-1:0]   target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        resolved_q;
    logic [31:0]        mispred_q;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] fb_idx;
    logic [TAG_W-1:0] fb_tag;
    logic             fb_hit;
    logic [1:0]       ctr_next;
    logic             unused_bits;

    assign unused_bits = if_pc_i[0] ^ fb_pc_i[0];

    // Lookup reads registered state only; same-cycle updates are not bypassed.
    assign if_idx        = if_pc_i[IDX_W:1];
    assign if_tag        = if_pc_i[BIT_W-1:IDX_W+1];
    assign pred_hit_o    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken_o  = pred_hit_o && (ctr_q[if_idx][1] || jump_q[if_idx]);
    assign pred_target_o = pred_hit_o ? target_q[if_idx] : '0;

    assign fb_idx = fb_pc_i[IDX_W:1];
    assign fb_tag = fb_pc_i[BIT_W-1:IDX_W+1];
    assign fb_hit = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);

    always_comb begin
        ctr_next = ctr_q[fb_idx];
        if (fb_taken_i) begin
            if (ctr_q[fb_idx] != CTR_ST) ctr_next = ctr_q[fb_idx] + 2'd1;
        end else begin
            if (ctr_q[fb_idx] != CTR_SN) ctr_next = ctr_q[fb_idx] - 2'd1;
        end
    end

    // Feedback is valid-only: every fb_valid_i strobe is accepted in its cycle, no back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            jump_q     <= '0;
            resolved_q <= '0;
            mispred_q  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WN;
            end
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end else if (fb_valid_i) begin
                if (fb_hit) begin
                    if (fb_jump_i) begin
                        ctr_q[fb_idx]    <= CTR_ST;
                        jump_q[fb_idx]   <= 1'b1;
                        target_q[fb_idx] <= fb_target_i;
                    end else begin
                        ctr_q[fb_idx] <= ctr_next;
                        if (fb_taken_i) target_q[fb_idx] <= fb_target_i;
                    end
                end else if (fb_taken_i) begin
                    valid_q[fb_idx]  <= 1'b1;
                    tag_q[fb_idx]    <= fb_tag;
                    target_q[fb_idx] <= fb_target_i;
                    jump_q[fb_idx]   <= fb_jump_i;
                    ctr_q[fb_idx]    <= fb_jump_i ? CTR_ST : CTR_WT;
                end
            end
            // Statistics count every strobe, flush or not.
            if (fb_valid_i) begin
                if (resolved_q != 32'hFFFF_FFFF) resolved_q <= resolved_q + 32'd1;
                if (fb_correction_i && !fb_jump_i && mispred_q != 32'hFFFF_FFFF)
                    mispred_q <= mispred_q + 32'd1;
            end
        end
    end

    assign stat_resolved_o = resolved_q;
    assign stat_mispred_o  = mispred_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed scenarios plus randomized
// feedback checked against an array-based reference model of the BTB.
module tb_branch_target_predictor;

    localparam int BIT_W   = 32;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic             clk;
    logic             rst;
    logic [BIT_W-1:0] if_pc_i;
    logic             pred_hit_o;
    logic             pred_taken_o;
    logic [BIT_W-1:0] pred_target_o;
    logic             fb_valid_i;
    logic [BIT_W-1:0] fb_pc_i;
    logic             fb_taken_i;
    logic             fb_jump_i;
    logic [BIT_W-1:0] fb_target_i;
    logic             fb_correction_i;
    logic             flush_i;
    logic [31:0]      stat_resolved_o;
    logic [31:0]      stat_mispred_o;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_predictor #(.BIT_W(BIT_W), .ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .if_pc_i(if_pc_i),
        .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .fb_valid_i(fb_valid_i), .fb_pc_i(fb_pc_i), .fb_taken_i(fb_taken_i),
        .fb_jump_i(fb_jump_i), .fb_target_i(fb_target_i), .fb_correction_i(fb_correction_i),
        .flush_i(flush_i), .stat_resolved_o(stat_resolved_o), .stat_mispred_o(stat_mispred_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: entry selected by (pc/2) mod ENTRIES, tag is pc / (2*ENTRIES).
    bit               m_valid  [ENTRIES];
    logic [BIT_W-1:0] m_tag    [ENTRIES];
    logic [BIT_W-1:0] m_target [ENTRIES];
    bit               m_jump   [ENTRIES];
    int               m_ctr    [ENTRIES];
    logic [31:0]      exp_resolved;
    logic [31:0]      exp_mispred;

    function automatic int m_index(logic [BIT_W-1:0] pc);
        return int'((pc / 2) % ENTRIES);
    endfunction

    function automatic logic [BIT_W-1:0] m_tagof(logic [BIT_W-1:0] pc);
        return pc / (2 * ENTRIES);
    endfunction

    function automatic logic [BIT_W+1:0] model_lookup(logic [BIT_W-1:0] pc);
        int i;
        bit hit;
        bit tk;
        i   = m_index(pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
        tk  = hit && (m_ctr[i] >= 2 || m_jump[i]);
        return {hit, tk, (hit ? m_target[i] : {BIT_W{1'b0}})};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_target[i] = '0; m_jump[i] = 0; m_ctr[i] = 1;
        end
        exp_resolved = '0;
        exp_mispred  = '0;
    endtask

    task automatic model_update(input logic v, input logic [BIT_W-1:0] pc, input logic tk,
                                input logic jp, input logic [BIT_W-1:0] tgt, input logic corr,
                                input logic fl);
        int i;
        bit hit;
        i   = m_index(pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
        if (v) begin
            if (exp_resolved != 32'hFFFF_FFFF) exp_resolved++;
            if (corr && !jp && exp_mispred != 32'hFFFF_FFFF) exp_mispred++;
        end
        if (fl) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
        end else if (v) begin
            if (hit && jp) begin
                m_ctr[i] = 3; m_jump[i] = 1; m_target[i] = tgt;
            end else if (hit) begin
                m_ctr[i] = tk ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1)
                              : ((m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1);
                if (tk) m_target[i] = tgt;
            end else if (tk) begin
                m_valid[i] = 1; m_tag[i] = m_tagof(pc); m_target[i] = tgt;
                m_jump[i] = jp; m_ctr[i] = jp ? 3 : 2;
            end
        end
    endtask

    // Driver: present feedback, clock it in, update the model on the same edge.
    task automatic step(input logic v, input logic [BIT_W-1:0] pc, input logic tk,
                        input logic jp, input logic [BIT_W-1:0] tgt, input logic corr,
                        input logic fl);
        fb_valid_i = v; fb_pc_i = pc; fb_taken_i = tk; fb_jump_i = jp;
        fb_target_i = tgt; fb_correction_i = corr; flush_i = fl;
        @(posedge clk);
        model_update(v, pc, tk, jp, tgt, corr, fl);
        #1;
        fb_valid_i = 1'b0; flush_i = 1'b0; fb_correction_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [BIT_W+1:0] exp;
        rst = 1'b1;
        if_pc_i = 32'h0000_0100;
        fb_valid_i = 0; fb_pc_i = '0; fb_taken_i = 0; fb_jump_i = 0;
        fb_target_i = '0; fb_correction_i = 0; flush_i = 0;
        model_reset();
        #3;
        exp = {2'b00, 32'h0};
        n_checks++;
        if ({pred_hit_o, pred_taken_o, pred_target_o} !== exp) begin
            n_fail++;
            $display("FAIL reset_lookup: got %h expected %h",
                     {pred_hit_o, pred_taken_o, pred_target_o}, exp);
        end
        n_checks++;
        if ({stat_resolved_o, stat_mispred_o} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h/%h expected 0/0", stat_resolved_o, stat_mispred_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_branch_learn();
        logic [BIT_W+1:0] exp;
        bit outcomes [6] = '{1, 0, 0, 0, 1, 1};
        for (int s = 0; s < 6; s++) begin
            step(1, 32'h0000_0040, outcomes[s], 0, 32'h0000_0080, 0, 0);
            if_pc_i = 32'h0000_0040;
            #1;
            exp = model_lookup(if_pc_i);
            n_checks++;
            if ({pred_hit_o, pred_taken_o, pred_target_o} !== exp) begin
                n_fail++;
                $display("FAIL branch_learn step %0d: got %h expected %h", s,
                         {pred_hit_o, pred_taken_o, pred_target_o}, exp);
            end
        end
        n_checks++;
        if (stat_resolved_o !== exp_resolved) begin
            n_fail++;
            $display("FAIL branch_resolved: got %0d expected %0d", stat_resolved_o, exp_resolved);
        end
    endtask

    task automatic test_jump();
        logic [BIT_W+1:0] exp;
        step(1, 32'h0000_0010, 1, 1, 32'h0000_0200, 1, 0);
        if_pc_i = 32'h0000_0010;
        #1;
        exp = model_lookup(if_pc_i);
        n_checks++;
        if ({pred_hit_o, pred_taken_o, pred_target_o} !== exp) begin
            n_fail++;
            $display("FAIL jump_lookup: got %h expected %h",
                     {pred_hit_o, pred_taken_o, pred_target_o}, exp);
        end
        n_checks++;
        if (stat_mispred_o !== exp_mispred) begin
            n_fail++;
            $display("FAIL jump_mispred: got %0d expected %0d", stat_mispred_o, exp_mispred);
        end
        // A corrected branch does count as a mispredict.
        step(1, 32'h0000_0022, 0, 0, 32'h0, 1, 0);
        n_checks++;
        if (stat_mispred_o !== exp_mispred) begin
            n_fail++;
            $display("FAIL branch_mispred: got %0d expected %0d", stat_mispred_o, exp_mispred);
        end
    endtask

    task automatic test_alias();
        logic [BIT_W-1:0] pcs [2] = '{32'h0000_0040, 32'h0000_0060};
        logic [BIT_W+1:0] exp;
        step(1, 32'h0000_0060, 1, 0, 32'h0000_0300, 0, 0);
        for (int k = 0; k < 2; k++) begin
            if_pc_i = pcs[k];
            #1;
            exp = model_lookup(if_pc_i);
            n_checks++;
            if ({pred_hit_o, pred_taken_o, pred_target_o} !== exp) begin
                n_fail++;
                $display("FAIL alias_lookup %h: got %h expected %h", pcs[k],
                         {pred_hit_o, pred_taken_o, pred_target_o}, exp);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [BIT_W+1:0] exp;
        if_pc_i = 32'h0000_0060;
        fb_valid_i = 1; fb_pc_i = 32'h0000_0060; fb_taken_i = 1; fb_jump_i = 0;
        fb_target_i = 32'h0000_0124; fb_correction_i = 1; flush_i = 0;
        #1;
        exp = model_lookup(if_pc_i);
        n_checks++;
        if ({pred_hit_o, pred_taken_o, pred_target_o} !== exp) begin
            n_fail++;
            $display("FAIL same_cycle_old: got %h expected %h",
                     {pred_hit_o, pred_taken_o, pred_target_o}, exp);
        end
        @(posedge clk);
        model_update(1, 32'h0000_0060, 1, 0, 32'h0000_0124, 1, 0);
        #1;
        fb_valid_i = 0; fb_correction_i = 0;
        #1;
        exp = model_lookup(if_pc_i);
        n_checks++;
        if ({pred_hit_o, pred_taken_o, pred_target_o} !== exp) begin
            n_fail++;
            $display("FAIL same_cycle_new: got %h expected %h",
                     {pred_hit_o, pred_taken_o, pred_target_o}, exp);
        end
    endtask

    task automatic test_flush();
        logic [BIT_W-1:0] pcs [3] = '{32'h0000_0010, 32'h0000_0060, 32'h0000_0090};
        logic [BIT_W+1:0] exp;
        step(1, 32'h0000_0090, 1, 0, 32'h0000_0400, 0, 1);
        for (int k = 0; k < 3; k++) begin
            if_pc_i = pcs[k];
            #1;
            exp = model_lookup(if_pc_i);
            n_checks++;
            if ({pred_hit_o, pred_taken_o, pred_target_o} !== exp) begin
                n_fail++;
                $display("FAIL flush_lookup %h: got %h expected %h", pcs[k],
                         {pred_hit_o, pred_taken_o, pred_target_o}, exp);
            end
        end
        n_checks++;
        if (stat_resolved_o !== exp_resolved) begin
            n_fail++;
            $display("FAIL flush_resolved: got %0d expected %0d", stat_resolved_o, exp_resolved);
        end
    endtask

    task automatic test_random();
        logic [BIT_W-1:0] pc, tgt;
        logic [BIT_W+1:0] exp;
        logic v, tk, jp, corr, fl;
        for (int it = 0; it < 300; it++) begin
            pc   = ($urandom_range(0, 3) << (IDX_W + 1)) | ($urandom_range(0, 3) << 1)
                   | $urandom_range(0, 1);
            v    = ($urandom_range(0, 3) != 0);
            jp   = ($urandom_range(0, 3) == 0);
            tk   = jp ? 1'b1 : 1'($urandom_range(0, 1));
            tgt  = $urandom & 32'hFFFF_FFFE;
            corr = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 40) == 0);
            if_pc_i = ($urandom_range(0, 3) << (IDX_W + 1)) | ($urandom_range(0, 3) << 1);
            fb_valid_i = v; fb_pc_i = pc; fb_taken_i = tk; fb_jump_i = jp;
            fb_target_i = tgt; fb_correction_i = corr; flush_i = fl;
            #1;
            exp = model_lookup(if_pc_i);
            n_checks++;
            if ({pred_hit_o, pred_taken_o, pred_target_o} !== exp) begin
                n_fail++;
                $display("FAIL random_lookup it %0d pc %h: got %h expected %h", it, if_pc_i,
                         {pred_hit_o, pred_taken_o, pred_target_o}, exp);
            end
            step(v, pc, tk, jp, tgt, corr, fl);
            n_checks++;
            if ({stat_resolved_o, stat_mispred_o} !== {exp_resolved, exp_mispred}) begin
                n_fail++;
                $display("FAIL random_stats it %0d: got %0d/%0d expected %0d/%0d", it,
                         stat_resolved_o, stat_mispred_o, exp_resolved, exp_mispred);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 32'h0000_0040, 1, 0, 32'h0000_0080, 0, 0);
        if_pc_i = 32'h0000_0040;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({pred_hit_o, pred_taken_o, pred_target_o} !== {model_lookup(if_pc_i)}) begin
            n_fail++;
            $display("FAIL async_reset_lookup: got %h expected 0",
                     {pred_hit_o, pred_taken_o, pred_target_o});
        end
        n_checks++;
        if ({stat_resolved_o, stat_mispred_o} !== {exp_resolved, exp_mispred}) begin
            n_fail++;
            $display("FAIL async_reset_stats: got %0d/%0d expected 0/0",
                     stat_resolved_o, stat_mispred_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_branch_learn();
        test_jump();
        test_alias();
        test_same_cycle();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
